// File: rtl/i2c_pkg.sv
// Shared I2C definitions used by both the target (i2c_slave_regs) and the master.
// Contents: protocol state enum, ACK/NACK bit levels, R/W bit levels.
// No ports; import with "import i2c_pkg::*;".
package i2c_pkg;

  // Target protocol states.
  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_e;

  // Level on SDA during the 9th (acknowledge) bit.
  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  // Value of bit 0 of the address byte.
  localparam logic I2C_WRITE = 1'b0;
  localparam logic I2C_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// I2C bus front end: synchronises SCL/SDA to clk and detects SCL edges, START and STOP.
// Ports: clk, rst (sync, active-low), scl_i/sda_i pads in; sda_o synchronised SDA;
//        scl_rise_o/scl_fall_o/start_o/stop_o single-clk event strobes (combinational from flops).
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_hist_q;
  logic       sda_hist_q;
  logic       scl_s;
  logic       sda_s;

  // Reset to the idle bus level so leaving reset never produces a false edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_hist_q <= scl_sync_q[1];
      sda_hist_q <= sda_sync_q[1];
    end
  end

  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];

  assign sda_o      = sda_s;
  assign scl_rise_o = scl_s & ~scl_hist_q;
  assign scl_fall_o = ~scl_s & scl_hist_q;
  // SCL must be high in both samples: an SDA change alongside an SCL edge is data, not a condition.
  assign start_o    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_o     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register file: index write, data write, read via repeated START.
// Ports: clk, rst (sync, active-low), scl in, sda open-drain inout, host_raddr/host_rdata local
//        read port, wr_stb/wr_idx/wr_data bus-write notification, busy (START..STOP).
// Build option: define I2C_SLAVE_AUTOINC_EN to advance the pointer after each written or ACKed read byte.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_COUNT  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         scl,
  inout  wire                          sda,
  input  logic [$clog2(REG_COUNT)-1:0] host_raddr,
  output logic [7:0]                   host_rdata,
  output logic                         wr_stb,
  output logic [$clog2(REG_COUNT)-1:0] wr_idx,
  output logic [7:0]                   wr_data,
  output logic                         busy
);

  localparam int IW = $clog2(REG_COUNT);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl),
    .sda_i     (sda),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  i2c_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          pull_q, pull_d;
  logic          busy_q, busy_d;
  logic          wr_stb_q, wr_stb_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    regs_q [REG_COUNT];
  logic [7:0]    byte_in;
  logic [7:0]    rd_byte;

  assign byte_in = {sh_q[6:0], sda_s};
  assign rd_byte = regs_q[ptr_q];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    ptr_d     = ptr_q;
    pull_d    = pull_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;

    if (stop_det) begin
      state_d = IDLE;
      pull_d  = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      pull_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (scl_rise) begin
      case (state_q)
        ADDR, REG, WDATA: begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            if (state_q == ADDR) begin
              state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
            end else if (state_q == REG) begin
              if ({1'b0, byte_in} < 9'(REG_COUNT)) begin
                ptr_d   = byte_in[IW-1:0];
                state_d = REG_ACK;
              end else begin
                state_d = WAIT_STOP;
              end
            end else begin
              wr_stb_d  = 1'b1;
              wr_idx_d  = ptr_q;
              wr_data_d = byte_in;
              if (AUTOINC) ptr_d = ptr_q + IW'(1);
              state_d   = WDATA_ACK;
            end
          end
        end
        // 9th clock of an ACK we drove: sh_q still holds the address byte, bit 0 is R/W.
        ADDR_ACK: begin
          cnt_d   = 4'd0;
          state_d = (sh_q[0] == I2C_READ) ? RDATA : REG;
        end
        REG_ACK, WDATA_ACK: begin
          cnt_d   = 4'd0;
          state_d = WDATA;
        end
        RDATA: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = RDATA_ACK;
        end
        RDATA_ACK: begin
          if (sda_s == I2C_ACK) begin
            cnt_d   = 4'd0;
            state_d = RDATA;
            if (AUTOINC) ptr_d = ptr_q + IW'(1);
          end else begin
            state_d = WAIT_STOP;
          end
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      // SDA only ever changes here, while SCL is low.
      case (state_q)
        ADDR_ACK, REG_ACK, WDATA_ACK: pull_d = 1'b1;
        RDATA: begin
          if (cnt_q == 4'd0) begin
            // First low phase after entry: fetch the byte and present its MSB.
            sh_d   = rd_byte;
            pull_d = ~rd_byte[7];
          end else begin
            sh_d   = {sh_q[6:0], 1'b0};
            pull_d = ~sh_q[6];
          end
        end
        default: pull_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      sh_q      <= 8'd0;
      ptr_q     <= '0;
      pull_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= 8'd0;
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      ptr_q     <= ptr_d;
      pull_q    <= pull_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      if (wr_stb_d) regs_q[wr_idx_d] <= wr_data_d;
    end
  end

  assign sda        = pull_q ? 1'b0 : 1'bz;
  assign host_rdata = regs_q[host_raddr];
  assign wr_stb     = wr_stb_q;
  assign wr_idx     = wr_idx_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-bangs an I2C master (8-clk SCL phases) and checks
// ACKs, read data, write strobes, register contents, busy and reset behaviour.
// Expected values are hand-computed; pointer-dependent ones follow I2C_SLAVE_AUTOINC_EN.
module tb_i2c_slave_regs;

  logic       clk;
  logic       rst;
  logic       scl;
  logic       m_sda;
  wire        sda;
  logic [3:0] host_raddr;
  logic [7:0] host_rdata;
  logic       wr_stb;
  logic [3:0] wr_idx;
  logic [7:0] wr_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  logic [3:0] last_idx = 4'd0;
  logic [7:0] last_data = 8'd0;

  assign sda = m_sda ? 1'bz : 1'b0;
  pullup (sda);

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .REG_COUNT(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl       (scl),
    .sda       (sda),
    .host_raddr(host_raddr),
    .host_rdata(host_rdata),
    .wr_stb    (wr_stb),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_cnt   = stb_cnt + 1;
      last_idx  = wr_idx;
      last_data = wr_data;
    end
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    wait_clk(4); m_sda = b;
    wait_clk(4); scl = 1'b1;
    wait_clk(4); seen = sda;
    wait_clk(4); scl = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(4); m_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); m_sda = 1'b0;
    wait_clk(8); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(4); m_sda = 1'b0;
    wait_clk(4); scl = 1'b1;
    wait_clk(8); m_sda = 1'b1;
    wait_clk(8);
  endtask

  // Returns the level seen during the 9th bit (0 = target ACK).
  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, ack);
  endtask

  // mack is the master's 9th bit; ack_seen is the bus level during it.
  task automatic read_byte(input logic mack, output logic [7:0] d, output logic ack_seen);
    for (int i = 7; i >= 0; i--) send_bit(1'b1, d[i]);
    send_bit(mack, ack_seen);
  endtask

  task automatic reg_at(input logic [3:0] idx, output logic [7:0] v);
    host_raddr = idx;
    wait_clk(1);
    v = host_rdata;
  endtask

  initial begin
    logic       a;
    logic [7:0] d;
    logic [7:0] v;
    logic [7:0] exp_r15, exp_r0, exp_ptr_read;
    logic       b1, b2, b3;

`ifdef I2C_SLAVE_AUTOINC_EN
    exp_r15 = 8'h11; exp_r0 = 8'h22; exp_ptr_read = 8'h00;
`else
    exp_r15 = 8'h22; exp_r0 = 8'h00; exp_ptr_read = 8'h22;
`endif

    rst = 1'b0; scl = 1'b1; m_sda = 1'b1; host_raddr = 4'd0;
    wait_clk(4);
    rst = 1'b1;
    wait_clk(4);

    // Reset state
    check8("rst_sda", {7'd0, sda}, 8'h01);
    check8("rst_busy", {7'd0, busy}, 8'h00);
    check8("rst_wr_stb", {7'd0, wr_stb}, 8'h00);
    check8("rst_wr_idx", {4'd0, wr_idx}, 8'h00);
    check8("rst_wr_data", wr_data, 8'h00);
    reg_at(4'd3, v); check8("rst_reg3", v, 8'h00);

    // 1. Basic write
    i2c_start();
    check8("w_busy", {7'd0, busy}, 8'h01);
    send_byte(8'hA0, a); check8("w_ack_addr", {7'd0, a}, 8'h00);
    send_byte(8'h03, a); check8("w_ack_idx", {7'd0, a}, 8'h00);
    send_byte(8'hA5, a); check8("w_ack_data", {7'd0, a}, 8'h00);
    i2c_stop();
    check_int("w_stb_cnt", stb_cnt, 1);
    check8("w_idx", {4'd0, last_idx}, 8'h03);
    check8("w_data", last_data, 8'hA5);
    reg_at(4'd3, v); check8("w_reg3", v, 8'hA5);
    check8("w_busy_end", {7'd0, busy}, 8'h00);

    // 2. Read via repeated START, master NACK
    i2c_start();
    send_byte(8'hA0, a); check8("r_ack_addr", {7'd0, a}, 8'h00);
    send_byte(8'h03, a); check8("r_ack_idx", {7'd0, a}, 8'h00);
    i2c_start();
    send_byte(8'hA1, a); check8("r_ack_raddr", {7'd0, a}, 8'h00);
    read_byte(1'b1, d, a);
    check8("r_data", d, 8'hA5);
    check8("r_nack_released", {7'd0, a}, 8'h01);
    check8("r_busy_before_stop", {7'd0, busy}, 8'h01);
    i2c_stop();
    check8("r_busy_end", {7'd0, busy}, 8'h00);
    check_int("r_stb_cnt", stb_cnt, 1);

    // 3. Address mismatch
    i2c_start();
    send_byte(8'hB0, a); check8("m_ack_addr", {7'd0, a}, 8'h01);
    send_byte(8'h03, a); check8("m_ack_idx", {7'd0, a}, 8'h01);
    send_byte(8'h11, a);
    i2c_stop();
    check_int("m_stb_cnt", stb_cnt, 1);
    reg_at(4'd3, v); check8("m_reg3", v, 8'hA5);

    // 4. Multi-byte write starting at the last register
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h0F, a);
    send_byte(8'h11, a); check8("mb_ack1", {7'd0, a}, 8'h00);
    send_byte(8'h22, a); check8("mb_ack2", {7'd0, a}, 8'h00);
    i2c_stop();
    check_int("mb_stb_cnt", stb_cnt, 3);
    reg_at(4'd15, v); check8("mb_reg15", v, exp_r15);
    reg_at(4'd0, v);  check8("mb_reg0", v, exp_r0);

    // 5. Index out of range
    i2c_start();
    send_byte(8'hA0, a); check8("oor_ack_addr", {7'd0, a}, 8'h00);
    send_byte(8'h20, a); check8("oor_nack_idx", {7'd0, a}, 8'h01);
    send_byte(8'h55, a); check8("oor_nack_data", {7'd0, a}, 8'h01);
    i2c_stop();
    check_int("oor_stb_cnt", stb_cnt, 3);
    reg_at(4'd15, v); check8("oor_reg15", v, exp_r15);

    // Read without an index reuses the retained pointer
    i2c_start();
    send_byte(8'hA1, a); check8("p_ack", {7'd0, a}, 8'h00);
    read_byte(1'b1, d, a);
    check8("p_data", d, exp_ptr_read);
    i2c_stop();

    // 6. Reset during the 4th data bit of a read of 0xA5 (bits 1,0,1,0...)
    i2c_start();
    send_byte(8'hA0, a);
    send_byte(8'h03, a);
    i2c_start();
    send_byte(8'hA1, a);
    send_bit(1'b1, b1);
    send_bit(1'b1, b2);
    send_bit(1'b1, b3);
    check8("rr_first_bits", {5'd0, b1, b2, b3}, 8'h05);
    wait_clk(4); m_sda = 1'b1;
    wait_clk(4); scl = 1'b1;
    wait_clk(4);
    check8("rr_sda_pulled", {7'd0, sda}, 8'h00);
    rst = 1'b0;
    wait_clk(1);
    check8("rr_sda_released", {7'd0, sda}, 8'h01);
    check8("rr_busy", {7'd0, busy}, 8'h00);
    reg_at(4'd3, v);  check8("rr_reg3", v, 8'h00);
    reg_at(4'd15, v); check8("rr_reg15", v, 8'h00);
    rst = 1'b1;
    wait_clk(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
